// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: single-outstanding imem fetch into a one-entry
// valid/ready output register, with PC-stage back-pressure and branch flush.
module ysyx_22040895_ifu #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce_i_ifu,
   input  logic [ADDR_W-1:0] pc_i_ifu,
   input  logic              flush_i_ifu,
   output logic              stall_o_ifu,
   output logic              imem_req_o_ifu,
   output logic [ADDR_W-1:0] imem_addr_o_ifu,
   input  logic              imem_gnt_i_ifu,
   input  logic              imem_rvalid_i_ifu,
   input  logic [INST_W-1:0] imem_rdata_i_ifu,
   output logic              valid_o_ifu,
   input  logic              ready_i_ifu,
   output logic [INST_W-1:0] inst_o_ifu,
   output logic [ADDR_W-1:0] instpc_o_ifu,
   output logic              misalign_o_ifu
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic              req_q;
   logic              valid_q;
   logic              consume;
   logic              free;
   logic              capture;
   logic              aligned;
   logic              load_mem;
   logic              load_mis;

   // A flushed entry is hidden immediately even though valid_q clears a cycle later.
   assign valid_o_ifu     = valid_q && !flush_i_ifu;
   assign consume         = valid_o_ifu && ready_i_ifu;
   assign free            = !valid_q || consume;
   assign capture         = (state == IDLE) && ce_i_ifu && free && !flush_i_ifu;
   assign aligned         = (pc_i_ifu[1:0] == 2'b00);
   assign load_mis        = capture && !aligned;
   assign load_mem        = (state == WAIT) && imem_rvalid_i_ifu && !flush_i_ifu;
   assign stall_o_ifu     = !capture;
   assign imem_req_o_ifu  = req_q;
   assign imem_addr_o_ifu = addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         addr  <= '0;
         req_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (capture && aligned) begin
                  addr  <= pc_i_ifu;
                  req_q <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (imem_gnt_i_ifu) begin
                  req_q <= 1'b0;
                  state <= flush_i_ifu ? DROP : WAIT;
               end else if (flush_i_ifu) begin
                  req_q <= 1'b0;
                  state <= IDLE;
               end
            end
            WAIT: begin
               // A granted request still owes us a response; DROP swallows it.
               if (flush_i_ifu) begin
                  state <= imem_rvalid_i_ifu ? IDLE : DROP;
               end else if (imem_rvalid_i_ifu) begin
                  state <= IDLE;
               end
            end
            DROP: begin
               if (imem_rvalid_i_ifu) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q        <= 1'b0;
         inst_o_ifu     <= '0;
         instpc_o_ifu   <= '0;
         misalign_o_ifu <= 1'b0;
      end else if (load_mem) begin
         valid_q        <= 1'b1;
         inst_o_ifu     <= imem_rdata_i_ifu;
         instpc_o_ifu   <= addr;
         misalign_o_ifu <= 1'b0;
      end else if (load_mis) begin
         valid_q        <= 1'b1;
         inst_o_ifu     <= '0;
         instpc_o_ifu   <= pc_i_ifu;
         misalign_o_ifu <= 1'b1;
      end else if (consume || flush_i_ifu) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Bench for ysyx_22040895_ifu: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch unit.
module tb_ysyx_22040895_ifu;
   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   typedef struct {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
      logic              mis;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ce = 1'b0, flush = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
   logic [ADDR_W-1:0] pc = '0;
   logic [INST_W-1:0] rdata = '0;
   logic              stall, req, valid, misalign;
   logic [ADDR_W-1:0] addr, instpc;
   logic [INST_W-1:0] inst;
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   ysyx_22040895_ifu #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .clk(clk), .rst(rst), .ce_i_ifu(ce), .pc_i_ifu(pc), .flush_i_ifu(flush),
      .stall_o_ifu(stall), .imem_req_o_ifu(req), .imem_addr_o_ifu(addr),
      .imem_gnt_i_ifu(gnt), .imem_rvalid_i_ifu(rvalid), .imem_rdata_i_ifu(rdata),
      .valid_o_ifu(valid), .ready_i_ifu(ready), .inst_o_ifu(inst),
      .instpc_o_ifu(instpc), .misalign_o_ifu(misalign)
   );

   task automatic drive(input logic c, input logic [ADDR_W-1:0] p, input logic f, input logic g,
                        input logic rv, input logic [INST_W-1:0] rd, input logic rdy);
      ce = c; pc = p; flush = f; gnt = g; rvalid = rv; rdata = rd; ready = rdy;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(0, '0, 0, 0, 0, '0, 0);
      #1 rst = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", req); end
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 1", stall); end
      checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", inst); end
      checks++; if (instpc !== 64'h0) begin errors++; $display("[TB] FAIL reset_instpc: got %h expected 0", instpc); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
      checks++; if (addr !== 64'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", addr); end
      tick();
      rst = 1'b1;
   endtask

   task automatic test_basic_fetch();
      drive(1, 64'h8000_0000, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL basic_cap_stall: got %b expected 0", stall); end
      checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL basic_cap_req: got %b expected 0", req); end
      tick();
      drive(1, 64'h8000_0004, 0, 1, 0, '0, 1);
      checks++; if (req !== 1'b1) begin errors++; $display("[TB] FAIL basic_req: got %b expected 1", req); end
      checks++; if (addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL basic_addr: got %h expected 80000000", addr); end
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_req_stall: got %b expected 1", stall); end
      tick();
      drive(1, 64'h8000_0004, 0, 0, 1, 32'h0000_0413, 1);
      checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_req: got %b expected 0", req); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_valid: got %b expected 0", valid); end
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL basic_wait_stall: got %b expected 1", stall); end
      tick();
      drive(1, 64'h8000_0004, 0, 0, 0, '0, 0);
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", valid); end
      checks++; if (inst !== 32'h0000_0413) begin errors++; $display("[TB] FAIL basic_inst: got %h expected 00000413", inst); end
      checks++; if (instpc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL basic_instpc: got %h expected 80000000", instpc); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL basic_misalign: got %b expected 0", misalign); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(1, 64'h8000_0004, 0, 0, 0, '0, 0);
         checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, valid); end
         checks++; if (inst !== 32'h0000_0413) begin errors++; $display("[TB] FAIL bp_inst[%0d]: got %h expected 00000413", i, inst); end
         checks++; if (instpc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL bp_instpc[%0d]: got %h expected 80000000", i, instpc); end
         checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall[%0d]: got %b expected 1", i, stall); end
         checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL bp_req[%0d]: got %b expected 0", i, req); end
      end
      tick();
      drive(1, 64'h8000_0004, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_stall: got %b expected 0", stall); end
      tick();
      drive(0, '0, 0, 1, 0, '0, 1);
      checks++; if (req !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_req: got %b expected 1", req); end
      checks++; if (addr !== 64'h8000_0004) begin errors++; $display("[TB] FAIL bp_next_addr: got %h expected 80000004", addr); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_consumed: got %b expected 0", valid); end
      tick();
      drive(0, '0, 0, 0, 1, 32'h0010_0093, 1);
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b1 || inst !== 32'h0010_0093 || instpc !== 64'h8000_0004) begin
         errors++; $display("[TB] FAIL bp_second: got v=%b %h@%h expected v=1 00100093@80000004", valid, inst, instpc); end
      tick();
   endtask

   task automatic test_gnt_delay();
      drive(1, 64'h8000_0100, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL gd_cap: got %b expected 0", stall); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, '0, 0, 0, 0, '0, 1);
         checks++; if (req !== 1'b1 || addr !== 64'h8000_0100) begin
            errors++; $display("[TB] FAIL gd_hold[%0d]: got req=%b addr=%h expected 1 80000100", i, req, addr); end
         tick();
      end
      drive(0, '0, 0, 1, 0, '0, 1);
      checks++; if (req !== 1'b1) begin errors++; $display("[TB] FAIL gd_gnt_req: got %b expected 1", req); end
      tick();
      drive(0, '0, 0, 0, 1, 32'h1234_5678, 1);
      checks++; if (req !== 1'b0) begin errors++; $display("[TB] FAIL gd_after_gnt: got %b expected 0", req); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b1 || inst !== 32'h1234_5678 || instpc !== 64'h8000_0100) begin
         errors++; $display("[TB] FAIL gd_resp: got v=%b %h@%h expected v=1 12345678@80000100", valid, inst, instpc); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL gd_single: got v=%b req=%b expected 0 0", valid, req); end
      tick();
   endtask

   task automatic test_flush_wait();
      drive(1, 64'h8000_0200, 0, 0, 0, '0, 1);
      tick();
      drive(0, '0, 0, 1, 0, '0, 1);
      tick();
      drive(0, '0, 1, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("[TB] FAIL fw_flush: got v=%b stall=%b expected 0 1", valid, stall); end
      tick();
      drive(1, 64'h8000_0300, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b1 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL fw_drop: got stall=%b req=%b expected 1 0", stall, req); end
      tick();
      drive(1, 64'h8000_0300, 0, 0, 1, 32'hdead_beef, 1);
      checks++; if (stall !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("[TB] FAIL fw_drop_resp: got stall=%b v=%b expected 1 0", stall, valid); end
      tick();
      drive(1, 64'h8000_0300, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("[TB] FAIL fw_discard: got v=%b stall=%b expected 0 0", valid, stall); end
      tick();
      drive(0, '0, 0, 1, 0, '0, 1);
      checks++; if (req !== 1'b1 || addr !== 64'h8000_0300) begin
         errors++; $display("[TB] FAIL fw_new_req: got req=%b addr=%h expected 1 80000300", req, addr); end
      tick();
      drive(0, '0, 0, 0, 1, 32'h0000_0013, 1);
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b1 || inst !== 32'h0000_0013 || instpc !== 64'h8000_0300) begin
         errors++; $display("[TB] FAIL fw_new_resp: got v=%b %h@%h expected v=1 00000013@80000300", valid, inst, instpc); end
      tick();
   endtask

   task automatic test_flush_gnt();
      drive(1, 64'h8000_0400, 0, 0, 0, '0, 1);
      tick();
      drive(0, '0, 1, 1, 0, '0, 1);
      checks++; if (req !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("[TB] FAIL fg_gnt: got req=%b v=%b expected 1 0", req, valid); end
      tick();
      drive(1, 64'h8000_0500, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b1 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL fg_drop: got stall=%b req=%b expected 1 0", stall, req); end
      tick();
      drive(0, '0, 0, 0, 1, 32'hcafe_babe, 1);
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL fg_resp: got %b expected 0", valid); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL fg_discard: got v=%b req=%b expected 0 0", valid, req); end
      tick();
   endtask

   task automatic test_flush_valid();
      drive(1, 64'h8000_0600, 0, 0, 0, '0, 0);
      tick();
      drive(0, '0, 0, 1, 0, '0, 0);
      tick();
      drive(0, '0, 0, 0, 1, 32'h1111_1111, 0);
      tick();
      drive(0, '0, 0, 0, 0, '0, 0);
      checks++; if (valid !== 1'b1 || inst !== 32'h1111_1111) begin
         errors++; $display("[TB] FAIL fv_held: got v=%b %h expected 1 11111111", valid, inst); end
      tick();
      drive(1, 64'h8000_0700, 1, 0, 0, '0, 0);
      checks++; if (valid !== 1'b0 || stall !== 1'b1) begin
         errors++; $display("[TB] FAIL fv_flush: got v=%b stall=%b expected 0 1", valid, stall); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 0);
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL fv_cleared: got %b expected 0", valid); end
      tick();
   endtask

   task automatic test_misalign();
      drive(1, 64'h8000_0002, 0, 0, 0, '0, 0);
      checks++; if (stall !== 1'b0 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL ma_cap: got stall=%b req=%b expected 0 0", stall, req); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 0);
      checks++; if (req !== 1'b0 || valid !== 1'b1 || misalign !== 1'b1) begin
         errors++; $display("[TB] FAIL ma_flags: got req=%b v=%b mis=%b expected 0 1 1", req, valid, misalign); end
      checks++; if (inst !== 32'h0 || instpc !== 64'h8000_0002) begin
         errors++; $display("[TB] FAIL ma_data: got %h@%h expected 00000000@80000002", inst, instpc); end
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL ma_consumed: got v=%b req=%b expected 0 0", valid, req); end
      tick();
   endtask

   task automatic test_reset_midfetch();
      drive(1, 64'h8000_0700, 0, 0, 0, '0, 1);
      tick();
      drive(0, '0, 0, 1, 0, '0, 1);
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      rst = 1'b0;
      #1;
      checks++; if (req !== 1'b0 || valid !== 1'b0 || stall !== 1'b1 || addr !== 64'h0) begin
         errors++; $display("[TB] FAIL rm_ctrl: got req=%b v=%b stall=%b addr=%h expected 0 0 1 0", req, valid, stall, addr); end
      checks++; if (inst !== 32'h0 || instpc !== 64'h0 || misalign !== 1'b0) begin
         errors++; $display("[TB] FAIL rm_data: got %h@%h mis=%b expected 0@0 0", inst, instpc, misalign); end
      tick();
      rst = 1'b1;
      drive(0, '0, 0, 0, 1, 32'h0bad_c0de, 1);
      tick();
      drive(0, '0, 0, 0, 0, '0, 1);
      checks++; if (valid !== 1'b0 || req !== 1'b0) begin
         errors++; $display("[TB] FAIL rm_stray: got v=%b req=%b expected 0 0", valid, req); end
      drive(1, 64'h8000_0800, 0, 0, 0, '0, 1);
      checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_recapture: got %b expected 0", stall); end
      tick();
   endtask

   task automatic test_random();
      entry_t            out_q[$];
      entry_t            e;
      bit                m_req, m_fly, m_discard, mem_out;
      logic [ADDR_W-1:0] m_addr;
      int                mem_cnt;
      logic              c, f, g, rv, rdy, exp_valid, free, cap;
      logic [ADDR_W-1:0] p;
      logic [INST_W-1:0] rd;
      drive(0, '0, 0, 0, 0, '0, 0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      m_req = 0; m_fly = 0; m_discard = 0; mem_out = 0; m_addr = '0; mem_cnt = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         c   = ($urandom % 4) != 0;
         p   = {$urandom, $urandom};
         if (($urandom % 8) != 0) p[1:0] = 2'b00;
         f   = ($urandom % 12) == 0;
         g   = m_req && ($urandom % 2 == 0);
         rv  = mem_out && (mem_cnt == 0);
         rd  = $urandom;
         rdy = ($urandom % 3) != 0;
         drive(c, p, f, g, rv, rd, rdy);
         exp_valid = (out_q.size() != 0) && !f;
         free      = (out_q.size() == 0) || (exp_valid && rdy);
         cap       = !m_req && !m_fly && c && free && !f;
         checks++; if (stall !== !cap) begin errors++; $display("[TB] FAIL rnd_stall @%0d: got %b expected %b", cyc, stall, !cap); end
         checks++; if (req !== m_req) begin errors++; $display("[TB] FAIL rnd_req @%0d: got %b expected %b", cyc, req, m_req); end
         checks++; if (valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid @%0d: got %b expected %b", cyc, valid, exp_valid); end
         if (m_req) begin
            checks++; if (addr !== m_addr) begin errors++; $display("[TB] FAIL rnd_addr @%0d: got %h expected %h", cyc, addr, m_addr); end
         end
         if (out_q.size() != 0) begin
            checks++; if (inst !== out_q[0].inst || instpc !== out_q[0].pc || misalign !== out_q[0].mis) begin
               errors++; $display("[TB] FAIL rnd_data @%0d: got %h@%h mis=%b expected %h@%h mis=%b",
                                  cyc, inst, instpc, misalign, out_q[0].inst, out_q[0].pc, out_q[0].mis); end
         end
         // Advance the model by one clock: retire, then fill the output slot.
         if ((exp_valid && rdy) || f) out_q.delete();
         if (cap) begin
            if (p[1:0] != 2'b00) begin
               e.inst = '0; e.pc = p; e.mis = 1'b1; out_q.push_back(e);
            end else begin
               m_req = 1; m_addr = p;
            end
         end else if (m_req) begin
            if (g) begin m_req = 0; m_fly = 1; m_discard = f; end
            else if (f) m_req = 0;
         end else if (m_fly) begin
            if (rv) begin
               m_fly = 0;
               if (!m_discard && !f) begin e.inst = rd; e.pc = m_addr; e.mis = 1'b0; out_q.push_back(e); end
            end else if (f) m_discard = 1;
         end
         if (g) begin mem_out = 1; mem_cnt = int'($urandom_range(3, 0)); end
         else if (rv) mem_out = 0;
         else if (mem_out && mem_cnt > 0) mem_cnt--;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_backpressure();
      test_gnt_delay();
      test_flush_wait();
      test_flush_gnt();
      test_flush_valid();
      test_misalign();
      test_reset_midfetch();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_22040895_ifu.md
# ysyx_22040895_ifu

Instruction fetch unit sitting directly downstream of the PC stage and upstream of decode. Each cycle it may capture the PC stage's fetch address, issues a single-outstanding request to instruction memory, and holds the returned 32-bit instruction with its PC in a one-entry output register under a valid/ready handshake. It back-pressures the PC stage through a stall output and discards in-flight fetches on a branch flush.

## Interface
- ADDR_W, 64, fetch address width
- INST_W, 32, instruction width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ce_i_ifu  in  1  PC stage chip enable; no capture while 0
- pc_i_ifu  in  ADDR_W  current fetch address from PC stage
- flush_i_ifu  in  1  branch redirect; kill in-flight and buffered fetch
- stall_o_ifu  out  1  PC stage must hold its PC while 1
- imem_req_o_ifu  out  1  memory request valid
- imem_addr_o_ifu  out  ADDR_W  request address
- imem_gnt_i_ifu  in  1  request accepted this cycle
- imem_rvalid_i_ifu  in  1  response data valid
- imem_rdata_i_ifu  in  INST_W  response instruction
- valid_o_ifu  out  1  output register holds a live instruction
- ready_i_ifu  in  1  decode accepts this cycle
- inst_o_ifu  out  INST_W  fetched instruction
- instpc_o_ifu  out  ADDR_W  PC of inst_o_ifu
- misalign_o_ifu  out  1  instpc_o_ifu[1:0] != 0; inst_o_ifu is 0

## Operation
- FSM states: IDLE, REQ, WAIT, DROP.
- free = !valid_q || (valid_o_ifu && ready_i_ifu).
- capture = (state==IDLE) && ce_i_ifu && free && !flush_i_ifu; stall_o_ifu = !capture (combinational).
- IDLE, capture, pc_i_ifu[1:0]==0: latch addr <= pc_i_ifu, go REQ.
- IDLE, capture, pc_i_ifu[1:0]!=0: no memory access; load output register (inst 0, instpc pc_i_ifu, misalign 1, valid 1); stay IDLE.
- REQ: imem_req_o_ifu=1, imem_addr_o_ifu=addr. gnt && !flush -> WAIT; gnt && flush -> DROP; !gnt && flush -> IDLE (request withdrawn); else hold.
- WAIT: rvalid && !flush -> load output register (rdata, addr, misalign 0, valid 1), go IDLE; flush (with or without rvalid) -> rvalid ? IDLE : DROP.
- DROP: wait for rvalid, discard data, go IDLE; flush in DROP has no extra effect.
- Output register: valid_o_ifu = valid_q && !flush_i_ifu. Handshake when valid_o_ifu && ready_i_ifu: clears valid_q unless reloaded same edge. Flush clears valid_q at the next edge. inst/instpc/misalign stable while valid_o_ifu && !ready_i_ifu.
- Load in WAIT is legal since IDLE→REQ required free and nothing else loads meanwhile.
- Memory: one outstanding request; rvalid arrives ≥1 cycle after gnt; rvalid outside WAIT/DROP is ignored.

## Timing
- Reset (rst=0, asynchronous): state IDLE, valid_q 0, inst_o_ifu 0, instpc_o_ifu 0, misalign_o_ifu 0, addr 0, imem_req_o_ifu 0. stall_o_ifu follows capture (1 while ce_i_ifu=0). Reset mid-fetch abandons the request; a later rvalid is ignored in IDLE.
- Aligned fetch, gnt on first REQ cycle, rvalid one cycle later: capture edge T0, req high T0+1, rvalid T0+2, valid_o_ifu high T0+3. Peak throughput one instruction per 3 cycles.
- Misaligned fetch: valid_o_ifu high the cycle after capture.
- stall_o_ifu is 0 only in IDLE-capture cycles; PC advances exactly once per captured fetch.

## Test plan
- Reset release, ce=1, pc=0x80000000, gnt immediate, rvalid next cycle with 0x00000413, ready=1 -> valid_o_ifu high 3 cycles after capture, inst 0x00000413, instpc 0x80000000, stall low only in capture cycle.
- ready_i_ifu=0 for 5 cycles after valid -> outputs held constant, no new capture, stall_o_ifu=1; ready=1 -> capture of pc 0x80000004 in the same cycle.
- gnt delayed 3 cycles -> imem_req_o_ifu and addr held stable all 3 cycles, single response consumed.
- flush in WAIT, rvalid 2 cycles later with 0xdeadbeef -> DROP entered, data discarded, valid_o_ifu never high for it, next capture fetches new pc_i_ifu.
- flush coincident with gnt; separately flush while valid_q=1 -> DROP entered; valid_o_ifu low in flush cycle and register cleared.
- pc_i_ifu=0x80000002 -> no imem_req_o_ifu, next cycle valid_o_ifu=1, misalign_o_ifu=1, inst 0; rst asserted in WAIT -> all outputs reset immediately, stray rvalid ignored.
